// File: rtl/blake2_host_feeder_if.sv
// Host/core/stream bundle for the blake2 host feeder.
// master = the feeder itself, slave = the surrounding host transport, core and sink.
interface blake2_host_feeder_if #(
   parameter int unsigned LL_W  = 128,
   parameter int unsigned IDX_W = 7,
   parameter int unsigned NN_W  = 7
);
   // host control
   logic             start_i;
   logic             empty_i;
   logic [NN_W-1:0]  kk_i;
   logic [NN_W-1:0]  nn_i;
   logic             busy_o;
   // message byte stream in
   logic             s_valid_i;
   logic             s_ready_o;
   logic [7:0]       s_data_i;
   logic             s_last_i;
   // blake2 core data port
   logic             core_ready_i;
   logic             core_data_v_o;
   logic [IDX_W-1:0] core_data_idx_o;
   logic [7:0]       core_data_o;
   logic             core_first_o;
   logic             core_last_o;
   logic [NN_W-1:0]  core_kk_o;
   logic [NN_W-1:0]  core_nn_o;
   logic [LL_W-1:0]  core_ll_o;
   logic             core_h_v_i;
   logic [7:0]       core_h_i;
   // digest byte stream out
   logic             m_valid_o;
   logic             m_ready_i;
   logic [7:0]       m_data_o;
   logic             m_last_o;

   modport master (
      input  start_i, empty_i, kk_i, nn_i, s_valid_i, s_data_i, s_last_i,
      input  core_ready_i, core_h_v_i, core_h_i, m_ready_i,
      output busy_o, s_ready_o, core_data_v_o, core_data_idx_o, core_data_o,
      output core_first_o, core_last_o, core_kk_o, core_nn_o, core_ll_o,
      output m_valid_o, m_data_o, m_last_o
   );

   modport slave (
      output start_i, empty_i, kk_i, nn_i, s_valid_i, s_data_i, s_last_i,
      output core_ready_i, core_h_v_i, core_h_i, m_ready_i,
      input  busy_o, s_ready_o, core_data_v_o, core_data_idx_o, core_data_o,
      input  core_first_o, core_last_o, core_kk_o, core_nn_o, core_ll_o,
      input  m_valid_o, m_data_o, m_last_o
   );
endinterface

// File: rtl/blake2_host_feeder.sv
// Packs a host byte stream into zero-padded 64-byte blake2 core blocks, captures the
// core's digest burst into a local buffer and replays it on a valid/ready stream.
module blake2_host_feeder #(
   parameter int unsigned BLOCK_B = 64,
   parameter int unsigned LL_W    = 128,
   parameter int unsigned IDX_W   = 7,
   parameter int unsigned NN_W    = 7,
   parameter int unsigned NN_MAX  = 64
) (
   input logic                  clk,
   input logic                  reset,
   blake2_host_feeder_if.master bus_io
);

   typedef enum logic [2:0] {StIdle, StLoad, StPad, StWaitH, StDrain} state_e;

   localparam int unsigned      BufAw   = $clog2(NN_MAX);
   localparam logic [IDX_W-1:0] IdxLast = IDX_W'(BLOCK_B - 1);

   state_e           state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [LL_W-1:0]  ll_q, ll_d;
   logic [NN_W-1:0]  kk_q, kk_d;
   logic [NN_W-1:0]  nn_q, nn_d;
   logic [NN_W-1:0]  wr_q, wr_d;
   logic [NN_W-1:0]  rd_q, rd_d;
   logic             first_q, first_d;
   logic             wake_q, wake_d;   // stale wake-up byte of the burst already dropped
   logic [7:0]       buf_q [NN_MAX];

   logic            start_ok, s_acc, idx_end, h_wr;
   logic [NN_W-1:0] nn_last;

   // Handshake qualifiers shared by the FSM, datapath and outputs
   always_comb begin
      start_ok = bus_io.start_i && (bus_io.nn_i != '0) && (bus_io.nn_i <= NN_W'(NN_MAX));
      s_acc    = (state_q == StLoad) && bus_io.s_valid_i && bus_io.core_ready_i;
      idx_end  = (idx_q == IdxLast);
      nn_last  = nn_q - NN_W'(1);
      h_wr     = (state_q == StWaitH) && bus_io.core_h_v_i && wake_q;
   end

   // Next-state and counter updates
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      ll_d    = ll_q;
      kk_d    = kk_q;
      nn_d    = nn_q;
      wr_d    = wr_q;
      rd_d    = rd_q;
      first_d = first_q;
      wake_d  = wake_q;
      case (state_q)
         StIdle: begin
            if (start_ok) begin
               state_d = bus_io.empty_i ? StPad : StLoad;
               idx_d   = '0;
               ll_d    = '0;
               kk_d    = bus_io.kk_i;
               nn_d    = bus_io.nn_i;
               wr_d    = '0;
               rd_d    = '0;
               first_d = 1'b1;
               wake_d  = 1'b0;
            end
         end
         StLoad: begin
            if (s_acc) begin
               ll_d  = ll_q + LL_W'(1);
               idx_d = idx_end ? '0 : idx_q + IDX_W'(1);
               if (idx_end) first_d = 1'b0;
               // the core keeps last on idx 63, so a full final block needs no pad block
               if (bus_io.s_last_i) state_d = idx_end ? StWaitH : StPad;
            end
         end
         StPad: begin
            if (bus_io.core_ready_i) begin
               idx_d = idx_end ? '0 : idx_q + IDX_W'(1);
               if (idx_end) begin
                  first_d = 1'b0;
                  state_d = StWaitH;
               end
            end
         end
         StWaitH: begin
            if (bus_io.core_h_v_i) begin
               if (!wake_q) begin
                  wake_d = 1'b1;
               end else begin
                  wr_d = wr_q + NN_W'(1);
                  if (wr_q == nn_last) state_d = StDrain;
               end
            end
         end
         StDrain: begin
            if (bus_io.m_ready_i) begin
               rd_d = rd_q + NN_W'(1);
               if (rd_q == nn_last) state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // State and counter registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= StIdle;
         idx_q   <= '0;
         ll_q    <= '0;
         kk_q    <= '0;
         nn_q    <= '0;
         wr_q    <= '0;
         rd_q    <= '0;
         first_q <= 1'b0;
         wake_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         ll_q    <= ll_d;
         kk_q    <= kk_d;
         nn_q    <= nn_d;
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         first_q <= first_d;
         wake_q  <= wake_d;
      end
   end

   // Digest buffer; contents only matter after a full capture, so no reset
   always_ff @(posedge clk) begin
      if (h_wr) buf_q[wr_q[BufAw-1:0]] <= bus_io.core_h_i;
   end

   // Outputs; core bytes pass through combinationally so data_v never outruns core ready
   always_comb begin
      bus_io.busy_o          = (state_q != StIdle);
      bus_io.s_ready_o       = (state_q == StLoad) && bus_io.core_ready_i;
      bus_io.core_data_v_o   = 1'b0;
      bus_io.core_data_o     = 8'h00;
      bus_io.core_last_o     = 1'b0;
      bus_io.core_data_idx_o = idx_q;
      bus_io.core_first_o    = first_q;
      bus_io.core_kk_o       = kk_q;
      bus_io.core_nn_o       = nn_q;
      bus_io.core_ll_o       = ll_q;
      bus_io.m_valid_o       = 1'b0;
      bus_io.m_data_o        = 8'h00;
      bus_io.m_last_o        = 1'b0;
      case (state_q)
         StLoad: begin
            bus_io.core_data_v_o = bus_io.s_valid_i && bus_io.core_ready_i;
            bus_io.core_data_o   = bus_io.s_data_i;
            bus_io.core_last_o   = bus_io.s_last_i;
         end
         StPad: begin
            bus_io.core_data_v_o = bus_io.core_ready_i;
            bus_io.core_last_o   = 1'b1;
         end
         StDrain: begin
            bus_io.m_valid_o = 1'b1;
            bus_io.m_data_o  = buf_q[rd_q[BufAw-1:0]];
            bus_io.m_last_o  = (rd_q == nn_last);
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_blake2_host_feeder.sv
// Bench for blake2_host_feeder: a small core model answers the data port and emits
// digest bursts; a block-level expectation model is checked by one negedge compare process.
module tb_blake2_host_feeder;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   blake2_host_feeder_if bus ();

   blake2_host_feeder dut (
      .clk    (clk),
      .reset  (reset),
      .bus_io (bus)
   );

   typedef struct {
      logic [6:0]   idx;
      logic [7:0]   data;
      logic         first;
      logic         last;
      logic [127:0] ll;
   } core_exp_t;

   core_exp_t   exp_core[$];
   logic [8:0]  exp_m[$];          // {last, data}
   logic [7:0]  msg [256];

   int n_cmp = 0;
   int n_err = 0;
   int cur_kk, cur_nn;
   bit m_rand, stray_en;

   // observations recorded by the compare process
   bit         xfer_n, xfer_last_n;
   int         xfer_idx_n;
   int         n_xfer, n_macc;
   logic [7:0] first_m, last_m;
   logic [127:0] ll_seen;
   bit         prev_stall;
   logic [7:0] prev_data;

   function automatic void chk(input string name, input logic [127:0] act,
                               input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endfunction

   // Model: message bytes, then zeros to a 64-byte boundary (at least one block)
   task automatic build_expect(input int len, input int nn);
      int nblk;
      core_exp_t e;
      nblk = (len == 0) ? 1 : (len + 63) / 64;
      for (int j = 0; j < nblk * 64; j++) begin
         e.idx   = 7'(j % 64);
         e.data  = (j < len) ? msg[j] : 8'h00;
         e.first = (j < 64);
         e.last  = (j >= len - 1);
         e.ll    = 128'((j < len) ? j : len);
         exp_core.push_back(e);
      end
      // wake byte k=0 is dropped; digest is core bytes k=1..nn
      for (int r = 0; r < nn; r++) exp_m.push_back({(r == nn - 1), 8'(8'h40 + r + 1)});
   endtask

   // Core model: drops ready for a compression after idx 63, then bursts nn+1 bytes
   int comp_cnt = 0, h_left = 0, h_k = 0;
   bit pend_last = 0;
   initial begin
      bus.core_ready_i = 1'b1;
      bus.core_h_v_i   = 1'b0;
      bus.core_h_i     = 8'h00;
      forever begin
         @(posedge clk);
         #1;
         if (reset) begin
            comp_cnt = 0;
            h_left   = 0;
            bus.core_ready_i = 1'b1;
            bus.core_h_v_i   = 1'b0;
         end else begin
            bus.core_h_v_i = 1'b0;
            if (h_left > 0) begin
               bus.core_h_v_i = 1'b1;
               bus.core_h_i   = 8'(64 + h_k);
               h_k++;
               h_left--;
            end else if (stray_en && xfer_n && xfer_idx_n == 5) begin
               bus.core_h_v_i = 1'b1;
               bus.core_h_i   = 8'hEE;
            end
            if (comp_cnt > 0) begin
               comp_cnt--;
               if (comp_cnt == 0) begin
                  bus.core_ready_i = 1'b1;
                  if (pend_last) begin
                     h_left = cur_nn + 1;
                     h_k    = 0;
                  end
               end
            end else if (xfer_n && xfer_idx_n == 63) begin
               bus.core_ready_i = 1'b0;
               comp_cnt  = 4;
               pend_last = xfer_last_n;
            end
         end
      end
   end

   // Downstream ready
   initial begin
      bus.m_ready_i = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         bus.m_ready_i = m_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   // Compare process: every cycle against the model queues
   initial begin
      core_exp_t e;
      logic [8:0] m;
      forever begin
         @(negedge clk);
         if (reset) begin
            xfer_n     = 0;
            prev_stall = 0;
         end else begin
            chk("core_v_gated", bus.core_data_v_o & ~bus.core_ready_i, 0);
            if (!bus.core_ready_i) chk("s_ready_stall", bus.s_ready_o, 0);
            xfer_n = bus.core_data_v_o;
            if (bus.core_data_v_o) begin
               xfer_idx_n  = int'(bus.core_data_idx_o);
               xfer_last_n = bus.core_last_o;
               n_xfer++;
               if (exp_core.size() == 0) begin
                  chk("core_extra_byte", n_xfer, 0);
               end else begin
                  e = exp_core.pop_front();
                  chk("core_idx", bus.core_data_idx_o, e.idx);
                  chk("core_data", bus.core_data_o, e.data);
                  chk("core_first", bus.core_first_o, e.first);
                  chk("core_last", bus.core_last_o, e.last);
                  chk("core_ll", bus.core_ll_o, e.ll);
                  chk("core_kk", bus.core_kk_o, cur_kk);
                  chk("core_nn", bus.core_nn_o, cur_nn);
               end
            end
            if (prev_stall) begin
               chk("m_valid_hold", bus.m_valid_o, 1);
               chk("m_data_hold", bus.m_data_o, prev_data);
            end
            if (bus.m_valid_o && bus.m_ready_i) begin
               n_macc++;
               if (n_macc == 1) first_m = bus.m_data_o;
               last_m  = bus.m_data_o;
               ll_seen = bus.core_ll_o;
               if (exp_m.size() == 0) begin
                  chk("m_extra_byte", n_macc, 0);
               end else begin
                  m = exp_m.pop_front();
                  chk("m_data", bus.m_data_o, m[7:0]);
                  chk("m_last", bus.m_last_o, m[8]);
               end
            end
            prev_stall = bus.m_valid_o && !bus.m_ready_i;
            prev_data  = bus.m_data_o;
         end
      end
   end

   task automatic clear_stats();
      n_xfer = 0;
      n_macc = 0;
      first_m = 8'h00;
      last_m  = 8'h00;
      ll_seen = '0;
   endtask

   // One complete hash: start, feed bytes (random gaps), wait for drain to finish
   task automatic run_hash(input int len, input bit empty, input int kk, input int nn,
                           input bit poke);
      int i = 0;
      int guard = 0;
      bit acc;
      clear_stats();
      build_expect(len, nn);
      cur_kk = kk;
      cur_nn = nn;
      bus.kk_i    = 7'(kk);
      bus.nn_i    = 7'(nn);
      bus.empty_i = empty;
      bus.start_i = 1'b1;
      @(posedge clk);
      #1;
      bus.start_i = 1'b0;
      bus.empty_i = 1'b0;
      bus.nn_i    = 7'd9;     // later changes must not reach the core
      bus.kk_i    = 7'd3;
      while (i < len && guard < 5000) begin
         bus.s_valid_i = ($urandom_range(0, 3) != 0);
         bus.s_data_i  = msg[i];
         bus.s_last_i  = (i == len - 1);
         bus.start_i   = poke && ($urandom_range(0, 3) == 0);
         @(negedge clk);
         acc = bus.s_valid_i && bus.s_ready_o;
         @(posedge clk);
         #1;
         bus.start_i = 1'b0;
         if (acc) i++;
         guard++;
      end
      bus.s_valid_i = 1'b0;
      bus.s_last_i  = 1'b0;
      chk("feed_count", i, len);
      guard = 0;
      while (bus.busy_o && guard < 5000) begin
         bus.start_i = poke && ($urandom_range(0, 3) == 0);
         @(posedge clk);
         #1;
         guard++;
      end
      bus.start_i = 1'b0;
      chk("run_done", bus.busy_o, 0);
      if (bus.busy_o) begin
         reset = 1'b1;
         #2 reset = 1'b0;
      end
      chk("core_queue_empty", exp_core.size(), 0);
      chk("m_queue_empty", exp_m.size(), 0);
      exp_core.delete();
      exp_m.delete();
      repeat (2) @(posedge clk);
      #1;
   endtask

   initial begin
      int i;
      int guard;
      bit acc;
      reset = 1'b1;
      m_rand = 0;
      stray_en = 0;
      bus.start_i = 0; bus.empty_i = 0; bus.kk_i = 0; bus.nn_i = 0;
      bus.s_valid_i = 0; bus.s_data_i = 0; bus.s_last_i = 0;
      #3;
      chk("rst_busy", bus.busy_o, 0);
      chk("rst_s_ready", bus.s_ready_o, 0);
      chk("rst_core_v", bus.core_data_v_o, 0);
      chk("rst_core_ll", bus.core_ll_o, 0);
      chk("rst_core_nn", bus.core_nn_o, 0);
      chk("rst_m_valid", bus.m_valid_o, 0);
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      @(posedge clk);
      #1;

      // illegal nn values: start ignored
      bus.nn_i = 7'd0; bus.start_i = 1'b1;
      @(posedge clk); #1;
      bus.nn_i = 7'd65;
      @(posedge clk); #1;
      bus.start_i = 1'b0;
      chk("start_nn_illegal", bus.busy_o, 0);

      // T1 empty message, nn=64
      run_hash(0, 1'b1, 0, 64, 1'b0);
      chk("t1_xfers", n_xfer, 64);
      chk("t1_m_count", n_macc, 64);
      chk("t1_first_m", first_m, 8'h41);
      chk("t1_last_m", last_m, 8'h80);
      chk("t1_ll", ll_seen, 0);

      // T2 "abc", nn=32
      msg[0] = 8'h61; msg[1] = 8'h62; msg[2] = 8'h63;
      run_hash(3, 1'b0, 0, 32, 1'b0);
      chk("t2_xfers", n_xfer, 64);
      chk("t2_m_count", n_macc, 32);
      chk("t2_last_m", last_m, 8'h60);
      chk("t2_ll", ll_seen, 3);

      // T3 exactly one full block, kk passed through
      for (int k = 0; k < 64; k++) msg[k] = 8'(k * 3 + 1);
      run_hash(64, 1'b0, 32, 16, 1'b0);
      chk("t3_xfers", n_xfer, 64);
      chk("t3_ll", ll_seen, 64);

      // T4 65 bytes: two blocks, compression stall between them
      for (int k = 0; k < 65; k++) msg[k] = 8'(255 - k);
      run_hash(65, 1'b0, 0, 8, 1'b0);
      chk("t4_xfers", n_xfer, 128);
      chk("t4_ll", ll_seen, 65);

      // T5 random m_ready, start pulsed while busy, stray h_v during LOAD
      for (int k = 0; k < 10; k++) msg[k] = 8'(8'hA0 + k);
      m_rand = 1;
      stray_en = 1;
      run_hash(10, 1'b0, 0, 20, 1'b1);
      chk("t5_m_count", n_macc, 20);
      chk("t5_first_m", first_m, 8'h41);
      m_rand = 0;
      stray_en = 0;

      // T6 reset mid-block at idx 20, then a clean T2 run
      for (int k = 0; k < 40; k++) msg[k] = 8'(8'h10 + k);
      clear_stats();
      build_expect(40, 16);
      cur_kk = 5; cur_nn = 16;
      bus.kk_i = 7'd5; bus.nn_i = 7'd16; bus.start_i = 1'b1;
      @(posedge clk); #1;
      bus.start_i = 1'b0;
      i = 0;
      guard = 0;
      while (n_xfer < 20 && guard < 1000) begin
         bus.s_valid_i = 1'b1;
         bus.s_data_i  = msg[i];
         bus.s_last_i  = 1'b0;
         @(negedge clk);
         acc = bus.s_valid_i && bus.s_ready_o;
         @(posedge clk); #1;
         if (acc) i++;
         guard++;
      end
      bus.s_data_i = msg[i];
      chk("t6_idx_before", bus.core_data_idx_o, 20);
      #2 reset = 1'b1;
      #1;
      chk("t6_busy", bus.busy_o, 0);
      chk("t6_s_ready", bus.s_ready_o, 0);
      chk("t6_core_v", bus.core_data_v_o, 0);
      chk("t6_core_idx", bus.core_data_idx_o, 0);
      chk("t6_core_data", bus.core_data_o, 0);
      chk("t6_core_first", bus.core_first_o, 0);
      chk("t6_core_last", bus.core_last_o, 0);
      chk("t6_core_kk", bus.core_kk_o, 0);
      chk("t6_core_nn", bus.core_nn_o, 0);
      chk("t6_core_ll", bus.core_ll_o, 0);
      chk("t6_m_valid", bus.m_valid_o, 0);
      chk("t6_m_data", bus.m_data_o, 0);
      chk("t6_m_last", bus.m_last_o, 0);
      bus.s_valid_i = 1'b0;
      exp_core.delete();
      exp_m.delete();
      repeat (2) @(posedge clk);
      #3 reset = 1'b0;
      @(posedge clk); #1;
      msg[0] = 8'h61; msg[1] = 8'h62; msg[2] = 8'h63;
      run_hash(3, 1'b0, 0, 32, 1'b0);
      chk("t6_t2_m_count", n_macc, 32);
      chk("t6_t2_ll", ll_seen, 3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
